// File: rtl/data_memory_if.sv
// Bus interface for data_memory: access controls from the pipeline MEM stage
// and read-back data from the memory.
// Optional DMEM_ERR_EN adds the err (misaligned/out-of-range) flag.
interface data_memory_if;
  logic        write;
  logic [31:0] address;
  logic [31:0] write_data;
  logic [31:0] read_data;
`ifdef DMEM_ERR_EN
  logic        err;

  modport master (output write, output address, output write_data,
                  input read_data, input err);
  modport slave  (input write, input address, input write_data,
                  output read_data, output err);
`else
  modport master (output write, output address, output write_data,
                  input read_data);
  modport slave  (input write, input address, input write_data,
                  output read_data);
`endif
endinterface

// File: rtl/data_memory.sv
// data_memory: word-organised data memory for the pipeline MEM stage.
// Byte address in, word index = address[IDX_W+1:2]; address[1:0] ignored.
// Combinational read, synchronous write, contents preloaded with mem[i]=i
// by the asynchronous active-low reset.
// Optional macro DMEM_ERR_EN: drives bus.err for misaligned or out-of-range
// addresses (forced low while in reset).
module data_memory #(
  parameter int DEPTH = 64,
  parameter int IDX_W = 6
) (
  input  logic         clk,
  input  logic         rst_n,
  data_memory_if.slave bus
);

  logic [31:0]      mem [DEPTH];
  logic [IDX_W-1:0] idx;
  logic             in_range;

  assign idx      = bus.address[IDX_W+1:2];
  assign in_range = (bus.address[31:IDX_W+2] == '0);

  // Preload on reset, otherwise store write_data into the addressed word;
  // out-of-range writes are dropped and never alias onto a legal word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= 32'(i);
      end
    end else if (bus.write == 1'b1 && in_range) begin
      mem[idx] <= bus.write_data;
    end
  end

  // Zero-latency read of the addressed word, zero when out of range.
  always_comb begin
    bus.read_data = 32'd0;
    if (in_range) begin
      bus.read_data = mem[idx];
    end
  end

`ifdef DMEM_ERR_EN
  // Flag misaligned or out-of-range accesses; quiet while in reset.
  always_comb begin
    bus.err = 1'b0;
    if (rst_n) begin
      bus.err = (bus.address[1:0] != 2'b00) || !in_range;
    end
  end
`else
  logic unused_byte_offset;
  assign unused_byte_offset = ^bus.address[1:0];
`endif

endmodule

// File: tb/tb_data_memory.sv
// tb_data_memory: scoreboard bench for data_memory. Stimulus pushes the
// expected response into a queue; a negedge monitor pops and compares.
// The reference model is a plain word array indexed by address/4.
module tb_data_memory;

  localparam int DEPTH = 64;
  localparam int IDX_W = 6;

  typedef struct {
    logic [31:0] data;
    logic        err;
    string       name;
  } expect_t;

  logic clk;
  logic rst_n;

  data_memory_if bus ();

  data_memory #(.DEPTH(DEPTH), .IDX_W(IDX_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  expect_t     sb [$];
  logic [31:0] model_mem [DEPTH];
  logic        pend_wr;
  int unsigned pend_idx;
  logic [31:0] pend_data;
  int          errors;
  int          checks;
  logic        in_reset;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic void model_reset();
    for (int i = 0; i < DEPTH; i++) model_mem[i] = i;
    pend_wr = 1'b0;
  endfunction

  function automatic logic model_in_range(input logic [31:0] a);
    return (a < 32'(4 * DEPTH));
  endfunction

  function automatic expect_t model_read(input logic [31:0] a, input string nm);
    expect_t e;
    e.name = nm;
    e.data = model_in_range(a) ? model_mem[a / 4] : 32'd0;
    e.err  = in_reset ? 1'b0 : ((a % 4 != 0) || !model_in_range(a));
    return e;
  endfunction

  // One access per cycle: retire last cycle's write in the model (the DUT
  // performed it on this posedge), drive the new access, queue its expectation.
  task automatic applyStimulus(input logic wr, input logic [31:0] addr,
                               input logic [31:0] wdata, input string nm);
    @(posedge clk);
    #1;
    if (pend_wr) model_mem[pend_idx] = pend_data;
    pend_wr        = 1'b0;
    bus.write      = wr;
    bus.address    = addr;
    bus.write_data = wdata;
    sb.push_back(model_read(addr, nm));
    if (wr && model_in_range(addr)) begin
      pend_wr   = 1'b1;
      pend_idx  = addr / 4;
      pend_data = wdata;
    end
  endtask

  // Pulse reset low between edges; the read must reinitialise without a clock.
  task automatic pulseReset(input logic [31:0] addr, input string nm);
    @(posedge clk);
    #1;
    if (pend_wr) model_mem[pend_idx] = pend_data;
    bus.write   = 1'b0;
    bus.address = addr;
    #1;
    rst_n    = 1'b0;
    in_reset = 1'b1;
    model_reset();
    #1;
    sb.push_back(model_read(addr, nm));
    @(negedge clk);
    #1;
    rst_n    = 1'b1;
    in_reset = 1'b0;
  endtask

  task automatic checkOutput(input expect_t e);
    checks++;
    if (bus.read_data !== e.data) begin
      errors++;
      $display("[TB] FAIL %s: read_data got %h expected %h", e.name, bus.read_data, e.data);
    end
`ifdef DMEM_ERR_EN
    checks++;
    if (bus.err !== e.err) begin
      errors++;
      $display("[TB] FAIL %s_err: err got %b expected %b", e.name, bus.err, e.err);
    end
`endif
  endtask

  // Monitor: compare whatever is queued once per cycle, away from posedge.
  initial begin
    forever begin
      @(negedge clk);
      if (sb.size() > 0) checkOutput(sb.pop_front());
    end
  end

  initial begin
    logic [31:0] a;
    logic [31:0] stable_val;
    errors         = 0;
    checks         = 0;
    rst_n          = 1'b0;
    in_reset       = 1'b1;
    bus.write      = 1'b0;
    bus.address    = 32'd12;
    bus.write_data = 32'd0;
    model_reset();
    #1;
    sb.push_back(model_read(32'd12, "reset_addr12"));
    @(negedge clk);
    #1;
    rst_n    = 1'b1;
    in_reset = 1'b0;
    $display("[TB] reset released");

    // Preloaded contents sweep
    applyStimulus(1'b0, 32'd12, 32'd0, "addr12");
    for (int i = 0; i < DEPTH; i++) applyStimulus(1'b0, 32'(4 * i), 32'd0, "sweep");

    // Write 0 to word 5: old value before edge, new value after, then held
    applyStimulus(1'b1, 32'd20, 32'd0, "wr20_before");
    applyStimulus(1'b0, 32'd20, 32'd0, "wr20_after");
    applyStimulus(1'b0, 32'd20, 32'd0, "wr20_hold");

    // Byte offsets within a word all alias to the same word
    applyStimulus(1'b1, 32'd8, 32'hDEADBEEF, "wr8");
    for (int i = 8; i < 12; i++) applyStimulus(1'b0, 32'(i), 32'd0, "rd_byteoff");
    applyStimulus(1'b0, 32'd12, 32'd0, "rd12_untouched");

    // Out-of-range write is dropped
    applyStimulus(1'b1, 32'(4 * DEPTH), 32'hFFFFFFFF, "oor_write");
    applyStimulus(1'b1, 32'hFFFF_FFFC, 32'hFFFFFFFF, "oor_write_high");
    applyStimulus(1'b0, 32'd13, 32'd0, "misaligned13");
    for (int i = 0; i < DEPTH; i++) applyStimulus(1'b0, 32'(4 * i), 32'd0, "post_oor_sweep");

    // Reset mid-cycle clears a written word
    applyStimulus(1'b1, 32'd0, 32'd7, "wr0_7");
    applyStimulus(1'b0, 32'd0, 32'd0, "rd0_7");
    pulseReset(32'd0, "reset_mid_cycle");
    applyStimulus(1'b0, 32'd0, 32'd0, "rd0_after_reset");

    // write=0 with toggling write_data leaves memory alone
    applyStimulus(1'b1, 32'd36, 32'hA5A5_0F0F, "wr36");
    for (int i = 0; i < 10; i++) applyStimulus(1'b0, 32'd36, $urandom, "no_write_toggle");
    stable_val = model_mem[9];
    applyStimulus(1'b0, 32'd36, 32'd0, "no_write_final");
    if (stable_val != 32'hA5A5_0F0F) $display("[TB] note: model word 9 unexpected");

    // Randomized traffic
    for (int n = 0; n < 300; n++) begin
      case ($urandom_range(0, 3))
        0: a = 32'(4 * $urandom_range(0, DEPTH - 1));
        1: a = 32'($urandom_range(0, 4 * DEPTH - 1));
        2: a = $urandom;
        default: a = 32'(4 * DEPTH) + 32'($urandom_range(0, 15));
      endcase
      applyStimulus(1'($urandom_range(0, 1)), a, $urandom, "random");
    end
    for (int i = 0; i < DEPTH; i++) applyStimulus(1'b0, 32'(4 * i), 32'd0, "final_sweep");

    // Drain: every queued expectation must have been compared
    repeat (4) @(negedge clk);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("[TB] FAIL drain: pending got %0d expected 0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
